// File: rtl/omr_pkg.sv
// Shared types and constants for the OMR sheet datapath (scanner, key loader, grader).
package omr_pkg;

  localparam int unsigned NUM_Q_DEF = 10;
  localparam int unsigned OPT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 4;

  // Keys are one-hot, so neither of these codes can ever grade as correct.
  localparam logic [OPT_W_DEF-1:0] BLANK_CODE = 4'b0000;
  localparam logic [OPT_W_DEF-1:0] MULTI_CODE = 4'b1111;

  typedef enum logic [1:0] {
    MARK_ONE,
    MARK_BLANK,
    MARK_MULTI
  } row_class_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_e;

endpackage

// File: rtl/omr_sheet_scanner_if.sv
// Sensor-row stream in, answer-word stream out; master = scanner, slave = sensor/grader side.
interface omr_sheet_scanner_if
  import omr_pkg::*;
#(
  parameter int unsigned NUM_Q = NUM_Q_DEF,
  parameter int unsigned OPT_W = OPT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic                     start;
  logic                     row_valid;
  logic [OPT_W-1:0]         row_data;
  logic                     row_ready;
  logic [NUM_Q*OPT_W-1:0]   answers;
  logic                     answers_valid;
  logic                     answers_ready;
  logic [CNT_W-1:0]         blank_count;
  logic [CNT_W-1:0]         multi_count;
  logic                     busy;
  logic                     scan_error;

  modport master (
    input  start, row_valid, row_data, answers_ready,
    output row_ready, answers, answers_valid, blank_count, multi_count, busy, scan_error
  );

  modport slave (
    output start, row_valid, row_data, answers_ready,
    input  row_ready, answers, answers_valid, blank_count, multi_count, busy, scan_error
  );

endinterface

// File: rtl/omr_row_encoder.sv
// Classifies one bubble row as single mark, blank or multi-mark and emits its answer nibble.
module omr_row_encoder
  import omr_pkg::*;
#(
  parameter int unsigned OPT_W = OPT_W_DEF
) (
  input  logic [OPT_W-1:0] row_data,
  output logic [OPT_W-1:0] code,
  output row_class_e       row_class
);

  always_comb begin
    code      = '1;
    row_class = MARK_MULTI;
    if (row_data == '0) begin
      code      = '0;
      row_class = MARK_BLANK;
    end else if ((row_data & (row_data - 1'b1)) == '0) begin
      // Clearing the lowest set bit leaves nothing only for a one-hot row.
      code      = row_data;
      row_class = MARK_ONE;
    end
  end

endmodule

// File: rtl/omr_sheet_scanner.sv
// Scans NUM_Q bubble rows per sheet into a packed answer word with blank/multi tallies.
// Optional idle-row abort in SCAN is built when SCAN_TIMEOUT_EN is defined.
module omr_sheet_scanner
  import omr_pkg::*;
#(
  parameter int unsigned NUM_Q          = NUM_Q_DEF,
  parameter int unsigned OPT_W          = OPT_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  omr_sheet_scanner_if.master bus
);

  localparam int unsigned IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_Q - 1);

  scan_state_e state, state_next;

  logic [NUM_Q*OPT_W-1:0] answers_q;
  logic [CNT_W-1:0]       blank_q;
  logic [CNT_W-1:0]       multi_q;
  logic [IDX_W-1:0]       idx;

  logic       accept;
  logic       clear;
  logic       timeout_hit;
  logic [OPT_W-1:0] code;
  row_class_e row_class;

  omr_row_encoder #(.OPT_W(OPT_W)) u_enc (
    .row_data  (bus.row_data),
    .code      (code),
    .row_class (row_class)
  );

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             scan_error_q;

  // Fires on the idle cycle that would make the count reach TIMEOUT_CYCLES.
  assign timeout_hit = (state == SCAN) && !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt      <= '0;
      scan_error_q <= 1'b0;
    end else begin
      scan_error_q <= timeout_hit;
      if (state != SCAN || accept || timeout_hit) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign bus.scan_error = scan_error_q;
`else
  assign timeout_hit    = 1'b0;
  assign bus.scan_error = 1'b0;
`endif

  always_comb begin
    state_next        = state;
    accept            = 1'b0;
    clear             = 1'b0;
    bus.row_ready     = 1'b0;
    bus.answers_valid = 1'b0;
    bus.busy          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clear      = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        bus.row_ready = 1'b1;
        bus.busy      = 1'b1;
        accept        = bus.row_valid;
        if (accept && idx == LAST_IDX) begin
          state_next = HOLD;
        end else if (timeout_hit) begin
          clear      = 1'b1;
          state_next = IDLE;
        end
      end
      HOLD: begin
        bus.answers_valid = 1'b1;
        bus.busy          = 1'b1;
        if (bus.answers_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      answers_q <= '0;
      blank_q   <= '0;
      multi_q   <= '0;
      idx       <= '0;
    end else if (accept) begin
      answers_q[idx*OPT_W +: OPT_W] <= code;
      if (row_class == MARK_BLANK) blank_q <= blank_q + CNT_W'(1);
      if (row_class == MARK_MULTI) multi_q <= multi_q + CNT_W'(1);
      idx <= idx + IDX_W'(1);
    end
  end

  assign bus.answers     = answers_q;
  assign bus.blank_count = blank_q;
  assign bus.multi_count = multi_q;

endmodule

// File: tb/tb_omr_sheet_scanner.sv
// Randomized scoreboard bench for omr_sheet_scanner; timeout checks run when SCAN_TIMEOUT_EN is defined.
module tb_omr_sheet_scanner;
  import omr_pkg::*;

  localparam int unsigned NQ = 10;
  localparam int unsigned OW = 4;
  localparam int unsigned CW = 4;

  typedef struct {
    logic [NQ*OW-1:0] ans;
    logic [CW-1:0]    blanks;
    logic [CW-1:0]    multis;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  omr_sheet_scanner_if #(.NUM_Q(NQ), .OPT_W(OW), .CNT_W(CW)) bus ();

  omr_sheet_scanner #(
    .NUM_Q(NQ), .OPT_W(OW), .CNT_W(CW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  exp_t        sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: classify each row by how many bubbles are darkened.
  function automatic exp_t model(input logic [3:0] rows [NQ]);
    exp_t e;
    e.ans = '0; e.blanks = '0; e.multis = '0;
    for (int i = 0; i < int'(NQ); i++) begin
      case ($countones(rows[i]))
        0:       e.blanks++;
        1:       e.ans[i*OW +: OW] = rows[i];
        default: begin e.multis++; e.ans[i*OW +: OW] = 4'hF; end
      endcase
    end
    return e;
  endfunction

  // Monitor: counts accepts, checks the HOLD timing and pops the scoreboard on each handshake.
  int unsigned     acc_cnt   = 0;
  bit              pend_hold = 1'b0;
  bit              pend_idle = 1'b0;
  logic [NQ*OW-1:0] last_ans = '0;

  always @(negedge clk) begin
    if (reset) begin
      acc_cnt = 0; pend_hold = 1'b0; pend_idle = 1'b0;
    end else begin
      if (pend_idle) begin
        check("valid_drops_after_handshake", bus.answers_valid, 0);
        check("idle_after_handshake", bus.busy, 0);
        check("answers_kept_in_idle", bus.answers, last_ans);
        pend_idle = 1'b0;
      end
      if (pend_hold) begin
        check("valid_cycle_after_last_row", bus.answers_valid, 1);
        pend_hold = 1'b0;
      end
      if (bus.answers_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", bus.answers_valid, 0);
        end else begin
          check("answers_stable", bus.answers, sb[0].ans);
          if (bus.answers_ready) begin
            check("blank_count", bus.blank_count, sb[0].blanks);
            check("multi_count", bus.multi_count, sb[0].multis);
            last_ans  = sb[0].ans;
            void'(sb.pop_front());
            pend_idle = 1'b1;
          end
        end
      end
      if (bus.scan_error) acc_cnt = 0;
      if (bus.row_valid && bus.row_ready) begin
        acc_cnt++;
        if (acc_cnt == NQ) begin
          pend_hold = 1'b1;
          acc_cnt   = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the edge that accepted the last row.
  task automatic send_rows(input logic [3:0] rows [NQ], input int unsigned n, input bit gaps);
    int unsigned i = 0;
    int unsigned budget = 0;
    logic acc;
    while (i < n && budget < 400) begin
      bus.row_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.row_data  = bus.row_valid ? rows[i] : 4'($urandom);
      bus.start     = gaps && !bus.row_valid && ($urandom_range(0, 3) == 0);
      acc = bus.row_valid && bus.row_ready;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (acc) i++;
      budget++;
    end
    bus.row_valid = 1'b0;
    if (i < n) check("rows_accepted_in_budget", i, n);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic run_sheet(input logic [3:0] rows [NQ], input bit gaps, input int unsigned stall);
    int unsigned w = 0;
    do_start();
    send_rows(rows, NQ, gaps);
    sb.push_back(model(rows));
    while (!bus.answers_valid && w < 8) begin @(posedge clk); #1; w++; end
    check("hold_reached", bus.answers_valid, 1);
    for (int unsigned s = 0; s < stall; s++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.row_valid = 1'($urandom_range(0, 1));
      bus.row_data  = 4'($urandom);
      @(posedge clk); #1;
      check("row_ready_low_in_hold", bus.row_ready, 0);
      check("valid_held_in_stall", bus.answers_valid, 1);
    end
    bus.start = 1'b0; bus.row_valid = 1'b0;
    bus.answers_ready = 1'b1;
    @(posedge clk); #1;
    bus.answers_ready = 1'b0;
  endtask

  task automatic random_rows(output logic [3:0] rows [NQ]);
    for (int i = 0; i < int'(NQ); i++)
      rows[i] = ($urandom_range(0, 9) < 6) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rows [NQ];

    reset = 1'b1;
    bus.start = 1'b0; bus.row_valid = 1'b0; bus.row_data = '0; bus.answers_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_answers", bus.answers, 0);
    check("reset_blank", bus.blank_count, 0);
    check("reset_multi", bus.multi_count, 0);
    check("reset_row_ready", bus.row_ready, 0);
    check("reset_valid", bus.answers_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_scan_error", bus.scan_error, 0);
    reset = 1'b0;

    // Rows and a stray answers_ready in IDLE must be ignored.
    bus.row_valid = 1'b1; bus.row_data = 4'b0010; bus.answers_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("row_ready_low_in_idle", bus.row_ready, 0);
      check("busy_low_in_idle", bus.busy, 0);
    end
    bus.row_valid = 1'b0; bus.answers_ready = 1'b0;

    for (int i = 0; i < int'(NQ); i++) rows[i] = 4'(1 << (i % 4));
    run_sheet(rows, 1'b0, 0);

    for (int i = 0; i < int'(NQ); i++) rows[i] = 4'b0001;
    rows[2] = 4'b0000; rows[7] = 4'b0000; rows[5] = 4'b0110;
    run_sheet(rows, 1'b0, 3);

    for (int k = 0; k < 5; k++) begin
      random_rows(rows);
      run_sheet(rows, 1'b1, (k == 0) ? 20 : $urandom_range(0, 6));
    end

    // Reset after four rows discards the partial sheet.
    do_start();
    random_rows(rows);
    send_rows(rows, 4, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midscan_reset_answers", bus.answers, 0);
    check("midscan_reset_blank", bus.blank_count, 0);
    check("midscan_reset_multi", bus.multi_count, 0);
    check("midscan_reset_busy", bus.busy, 0);
    check("midscan_reset_row_ready", bus.row_ready, 0);
    random_rows(rows);
    run_sheet(rows, 1'b1, 2);

`ifdef SCAN_TIMEOUT_EN
    do_start();
    rows[0] = 4'b0000; rows[1] = 4'b0110; rows[2] = 4'b0001;
    send_rows(rows, 3, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("scan_error_cycle_%0d", k), bus.scan_error, (k == 8) ? 1 : 0);
      check("no_valid_on_timeout", bus.answers_valid, 0);
    end
    #1;
    check("timeout_answers_cleared", bus.answers, 0);
    check("timeout_blank_cleared", bus.blank_count, 0);
    check("timeout_multi_cleared", bus.multi_count, 0);
    check("timeout_idle", bus.busy, 0);
    @(posedge clk); #1;
    random_rows(rows);
    run_sheet(rows, 1'b0, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/omr_sheet_scanner.md
Name: omr_sheet_scanner

Overview:
- Front end of the OMR datapath. Accepts one bubble row per question from the optical sensor interface, over a valid/ready stream.
- Classifies each row as a single mark, a blank or a multi-mark, and packs the encoded nibbles into a NUM_Q*OPT_W answer word.
- Presents the word to the grading block over a valid/ready handshake, with per-sheet blank and multi-mark tallies.
- Producer side of the answer-vector interface the grader consumes.

Parameters:
- NUM_Q, 10, questions per sheet; rows accepted per scan.
- OPT_W, 4, bubbles per question (options A..D); nibble width.
- CNT_W, 4, width of tally outputs; must be at least clog2(NUM_Q+1).
- TIMEOUT_CYCLES, 255, idle-row limit in SCAN; used only with SCAN_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; returns all state to IDLE.
- start  in  1  begin a new sheet; sampled only in IDLE.
- row_valid  in  1  sensor row present.
- row_data  in  OPT_W  raw bubble bits; bit k = option k darkened.
- row_ready  out  1  high only in SCAN.
- answers  out  NUM_Q*OPT_W  packed codes; question i at [i*OPT_W +: OPT_W].
- answers_valid  out  1  high in HOLD.
- answers_ready  in  1  grader accepts the word.
- blank_count  out  CNT_W  blank questions on the current sheet.
- multi_count  out  CNT_W  multi-marked questions on the current sheet.
- busy  out  1  high in SCAN or HOLD.
- scan_error  out  1  one-cycle pulse on timeout abort (SCAN_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset values: state IDLE; answers, blank_count, multi_count, question index, timeout counter all 0; row_ready, answers_valid, busy, scan_error all 0.
- Encoding (per accepted row):
  - exactly one bit set -> row_data unchanged (one-hot code).
  - zero bits set -> BLANK_CODE 4'b0000, blank_count+1.
  - two or more bits set -> MULTI_CODE 4'b1111, multi_count+1.
  - Answer keys are one-hot, so BLANK_CODE and MULTI_CODE never match a key.
- States:
  - IDLE: row_ready=0. On start=1: clear answers, tallies and index; go to SCAN next cycle.
  - SCAN: row_ready=1. A row is accepted on row_valid&&row_ready; it writes the slot at the current index, then the index increments. The first row is question 0. The cycle that accepts row NUM_Q-1 moves to HOLD, so answers_valid rises the cycle after the last row is accepted.
  - HOLD: answers_valid=1. answers and tallies are frozen until answers_ready=1. On that handshake cycle go to IDLE; answers_valid=0 on the following cycle.
- answers and tallies keep their values in IDLE until the next start, so they can be read after the handshake.
- start outside IDLE is ignored. row_valid outside SCAN is ignored (row_ready=0, no stall side effect).
- answers_ready while answers_valid=0 has no effect.
- Tallies never wrap: the maximum is NUM_Q, which CNT_W must hold.
- reset has priority over every event. Reset mid-SCAN or mid-HOLD discards the partial sheet and returns all outputs to their reset values on the next edge.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro SCAN_TIMEOUT_EN.
- Defined:
  - A counter increments each SCAN cycle with no accepted row and clears on every accepted row.
  - When it reaches TIMEOUT_CYCLES: pulse scan_error for one cycle, return to IDLE, clear answers and tallies to 0, do not assert answers_valid.
- Undefined:
  - No counter is built; scan_error is tied 0.
  - SCAN waits for rows indefinitely.

Decomposition:
- Package omr_pkg:
  - NUM_Q and OPT_W defaults.
  - BLANK_CODE and MULTI_CODE constants.
  - Row-class enum: MARK_ONE, MARK_BLANK, MARK_MULTI.
  - Scanner state enum: IDLE, SCAN, HOLD.
- Sub-module omr_row_encoder: combinational. Takes row_data; outputs the encoded nibble and the row class. It is reused by the key-loading path.

Test Plan:
- Clean sheet:
  - Stimulus: start, then rows 0001,0010,0100,1000 repeating across 10 questions, with no gaps.
  - Required: answers_valid rises the cycle after the 10th accept; answers = 40'h2184218421 (question 0 in the LSB nibble); blank_count=0, multi_count=0.
- Blanks and multi-marks:
  - Stimulus: rows 0000 at questions 2 and 7; 0110 at question 5; the rest 0001.
  - Required: nibbles 2 and 7 = 0, nibble 5 = F; blank_count=2, multi_count=1.
- Backpressure and gaps:
  - Stimulus: row_valid toggles randomly in SCAN; answers_ready held low for 20 cycles in HOLD.
  - Required: every row is accepted exactly once; answers and answers_valid stay stable through the stall; return to IDLE the cycle after answers_ready=1.
- Ignored inputs:
  - Stimulus: start pulsed in SCAN and in HOLD; row_valid=1 in IDLE.
  - Required: state unchanged, no row consumed, row_ready=0 outside SCAN.
- Reset mid-scan:
  - Stimulus: reset asserted after 4 rows.
  - Required: next cycle state IDLE, answers=0, tallies=0, busy=0; a following sheet scans normally from question 0.
- SCAN_TIMEOUT_EN:
  - Stimulus: TIMEOUT_CYCLES=8; 3 rows, then silence.
  - Required: a single scan_error pulse 8 cycles after the last accepted row; answers_valid never rises; answers=0; next start works.
